// File: rtl/alu_ctrl_pkg.sv
// ALU control codes used by the decoder, the ALU and the multiply sequencer,
// plus the state encoding of the multiply sequencer FSM.
package alu_ctrl_pkg;

  localparam logic [2:0] AluAnd  = 3'b000;
  localparam logic [2:0] AluXor  = 3'b001;
  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluSll  = 3'b011;
  localparam logic [2:0] AluSrai = 3'b100;
  localparam logic [2:0] AluAddi = 3'b101;
  localparam logic [2:0] AluSub  = 3'b110;
  localparam logic [2:0] AluMul  = 3'b111;

  localparam logic [1:0] MulStIdle = 2'd0;
  localparam logic [1:0] MulStRun  = 2'd1;
  localparam logic [1:0] MulStDone = 2'd2;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: one multiplier bit per step, low WIDTH product bits kept.
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage multi-cycle multiply sequencer: stalls the front of the pipe for a MUL,
// iterates WIDTH shift-add steps, then presents the product for one cycle.
module mul_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             mul_done_o,
  output logic [WIDTH-1:0] mul_result_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc;
  logic             start;
  logic             step;
  logic             done;

  assign start = valid_i && (ALUCtrl_i == AluMul) && (state_q == MulStIdle) && !flush_i;
  assign done  = (state_q == MulStDone) && !flush_i;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    step    = 1'b0;
    case (state_q)
      MulStIdle: begin
        if (start) begin
          state_d = MulStRun;
          count_d = '0;
        end
      end
      MulStRun: begin
        if (flush_i) begin
          state_d = MulStIdle;
        end else begin
          step    = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (count_q == LastCnt) begin
            state_d = MulStDone;
          end
        end
      end
      MulStDone: state_d = MulStIdle;
      default:   state_d = MulStIdle;
    endcase
    busy_d = (state_d == MulStRun);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MulStIdle;
      count_q  <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      if (done) begin
        result_q <= acc;
      end
    end
  end

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (start),
    .step_i  (step),
    .mcand_i (rs1_data_i),
    .mplier_i(rs2_data_i),
    .acc_o   (acc)
  );

  // In DONE the finished accumulator is shown directly; a flush there keeps the old product.
  assign mul_result_o = done ? acc : result_q;
  assign mul_done_o   = done;
  assign busy_o       = busy_q;
  assign stall_o      = !rst_i && !flush_i && (start || (state_q == MulStRun));

endmodule
